block_miner: RTL and testbench

BLOCK_MINER -- requirements
Module: block_miner

---
 rtl/block_miner.sv | 184 ++++++++++++++++++
 tb/tb_block_miner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_miner.sv
// ---------------------------------------------------------------------------
// block_miner
//   Proof-of-work search over an 8-bit nonce. It hashes seven bytes (six
//   message bytes, then the working nonce) through a 32-entry substitution
//   table, one byte per cycle. The search stops at the first nonce whose hash
//   has DIFFICULTY leading zero bits.
//
// Parameters
//   DIFFICULTY     number of hash MSBs that must be zero (0..8)
//
// Ports
//   clock          single clock, rising edge
//   reset          synchronous, active-high
//   enable_mining  level request; hold high until done_mining/mining_failed
//   previous_hash  chain seed h0, latched at start
//   message        48-bit payload, latched at start
//   random_table   T[k] = random_table[8k+7:8k], k = 0..31 (bits 287:256 unused)
//   busy           high while in HASH or CHECK
//   new_hash       winning hash
//   nonce          winning nonce
//   final_message  {nonce, new_hash, message}
//   done_mining    success flag, held in DONE
//   mining_failed  nonce space exhausted (only with MINER_TIMEOUT_EN)
//   dbg_state      current FSM state encoding, for observation
//
// Configuration macro: MINER_TIMEOUT_EN
//   Defined   : rejecting nonce 255 ends the search in FAIL.
//   Undefined : the nonce wraps and the search continues indefinitely.
//
// Handshake: enable_mining is a level request. A rising request in IDLE
// starts a search. Dropping it at any point returns the FSM to IDLE on the
// next edge. done_mining / mining_failed stay asserted until it drops.
// ---------------------------------------------------------------------------
module block_miner #(
    parameter int DIFFICULTY = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable_mining,
    input  logic [7:0]   previous_hash,
    input  logic [47:0]  message,
    input  logic [287:0] random_table,
    output logic         busy,
    output logic [7:0]   new_hash,
    output logic [7:0]   nonce,
    output logic [63:0]  final_message,
    output logic         done_mining,
    output logic         mining_failed,
    output logic [2:0]   dbg_state
);

`ifdef MINER_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, HASH, CHECK, DONE, FAIL} state_t;
`else
    typedef enum logic [2:0] {IDLE, HASH, CHECK, DONE} state_t;
`endif

    // Mask of the hash bits that must be zero. Shifting a 16-bit pattern
    // gives an empty mask for DIFFICULTY = 0 without an illegal slice.
    localparam logic [15:0] MASK_WIDE = 16'hFF00 >> DIFFICULTY;
    localparam logic [7:0]  ZERO_MASK = MASK_WIDE[7:0];

    state_t         state;
    logic [7:0]     prev_q;
    logic [47:0]    msg_q;
    logic [255:0]   table_q;   // latched so later table changes cannot affect a run
    logic [7:0]     h;
    logic [7:0]     work_nonce;
    logic [2:0]     step;
    logic           failed_q;

    logic [7:0]     cur_byte;
    logic [4:0]     idx;
    logic [7:0]     h_next;
    logic           accept;

    always_comb begin
        cur_byte = work_nonce;
        if (step < 3'd6)
            cur_byte = msg_q[{step, 3'b000} +: 8];
        idx    = h[4:0] ^ cur_byte[4:0];
        h_next = table_q[{idx, 3'b000} +: 8];
        accept = ((h & ZERO_MASK) == 8'h00);
    end

    assign dbg_state = state;

`ifdef MINER_TIMEOUT_EN
    assign mining_failed = failed_q;
`else
    assign mining_failed = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            prev_q        <= 8'h00;
            msg_q         <= 48'h0;
            table_q       <= 256'h0;
            h             <= 8'h00;
            work_nonce    <= 8'h00;
            step          <= 3'd0;
            busy          <= 1'b0;
            new_hash      <= 8'h00;
            nonce         <= 8'h00;
            final_message <= 64'h0;
            done_mining   <= 1'b0;
            failed_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy        <= 1'b0;
                    done_mining <= 1'b0;
                    failed_q    <= 1'b0;
                    if (enable_mining) begin
                        prev_q     <= previous_hash;
                        msg_q      <= message;
                        table_q    <= random_table[255:0];
                        h          <= previous_hash;
                        work_nonce <= 8'h00;
                        step       <= 3'd0;
                        busy       <= 1'b1;
                        state      <= HASH;
                    end
                end
                HASH: begin
                    if (!enable_mining) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        h    <= h_next;
                        step <= step + 3'd1;
                        if (step == 3'd6)
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!enable_mining) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (accept) begin
                        new_hash      <= h;
                        nonce         <= work_nonce;
                        final_message <= {work_nonce, h, msg_q};
                        done_mining   <= 1'b1;
                        busy          <= 1'b0;
                        state         <= DONE;
`ifdef MINER_TIMEOUT_EN
                    end else if (work_nonce == 8'hFF) begin
                        failed_q <= 1'b1;
                        busy     <= 1'b0;
                        state    <= FAIL;
`endif
                    end else begin
                        // Next attempt restarts the chain from the latched seed.
                        work_nonce <= work_nonce + 8'd1;
                        h          <= prev_q;
                        step       <= 3'd0;
                        state      <= HASH;
                    end
                end
                DONE: begin
                    if (!enable_mining) begin
                        done_mining <= 1'b0;
                        state       <= IDLE;
                    end
                end
`ifdef MINER_TIMEOUT_EN
                FAIL: begin
                    if (!enable_mining) begin
                        failed_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_miner.sv
// ---------------------------------------------------------------------------
// tb_block_miner
//   Three miners (DIFFICULTY 3, 1 and 0) share one set of inputs. sel picks
//   which one the monitor watches. Stimulus pushes the expected result of
//   each run into exp_q. The monitor pops and compares an entry whenever the
//   selected miner raises done_mining or mining_failed.
//   Entry layout: {kind(1: fail), latency(16), nonce(8), hash(8), final(64)}.
//   Latency counts the start edge as cycle 0; a flag that is visible just
//   after edge N of the run is at cycle N+1.
// ---------------------------------------------------------------------------
module tb_block_miner;

    logic         clock;
    logic         reset;
    logic         enable_mining;
    logic [7:0]   previous_hash;
    logic [47:0]  message;
    logic [287:0] random_table;

    logic         busy   [3];
    logic [7:0]   hsh    [3];
    logic [7:0]   nnc    [3];
    logic [63:0]  fmsg   [3];
    logic         done   [3];
    logic         failed [3];
    logic [2:0]   st     [3];

    block_miner #(.DIFFICULTY(3)) u_d3 (
        .clock(clock), .reset(reset), .enable_mining(enable_mining),
        .previous_hash(previous_hash), .message(message), .random_table(random_table),
        .busy(busy[0]), .new_hash(hsh[0]), .nonce(nnc[0]), .final_message(fmsg[0]),
        .done_mining(done[0]), .mining_failed(failed[0]), .dbg_state(st[0]));

    block_miner #(.DIFFICULTY(1)) u_d1 (
        .clock(clock), .reset(reset), .enable_mining(enable_mining),
        .previous_hash(previous_hash), .message(message), .random_table(random_table),
        .busy(busy[1]), .new_hash(hsh[1]), .nonce(nnc[1]), .final_message(fmsg[1]),
        .done_mining(done[1]), .mining_failed(failed[1]), .dbg_state(st[1]));

    block_miner #(.DIFFICULTY(0)) u_d0 (
        .clock(clock), .reset(reset), .enable_mining(enable_mining),
        .previous_hash(previous_hash), .message(message), .random_table(random_table),
        .busy(busy[2]), .new_hash(hsh[2]), .nonce(nnc[2]), .final_message(fmsg[2]),
        .done_mining(done[2]), .mining_failed(failed[2]), .dbg_state(st[2]));

    // ---------------- clock / cycle counter ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [96:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;
    int start_cyc = 0;
    int events_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [96:0] mk_exp(input logic kind, input int lat,
                                           input logic [7:0] n, input logic [7:0] hv,
                                           input logic [63:0] fm);
        logic [15:0] l16;
        l16 = 16'(lat);
        return {kind, l16, n, hv, fm};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic pd, pf, d, f;
        logic [96:0] e;
        pd = 1'b0;
        pf = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            d = done[sel];
            f = failed[sel];
            if ((d && !pd) || (f && !pf)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: done=%0b failed=%0b with empty queue", d, f);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(cyc - start_cyc + 1), 64'(e[95:80]));
                    if (e[96]) begin
                        check("fail_flag", 64'(f), 64'd1);
                        check("fail_no_done", 64'(d), 64'd0);
                    end else begin
                        check("done_flag", 64'(d), 64'd1);
                        check("nonce", 64'(nnc[sel]), 64'(e[79:72]));
                        check("new_hash", 64'(hsh[sel]), 64'(e[71:64]));
                        check("final_message", fmsg[sel], e[63:0]);
                    end
                end
                events_seen++;
            end
            pd = d;
            pf = f;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [287:0] tbl_fill(input logic [7:0] base, input logic ident,
                                              input int hole, input logic [7:0] hole_v);
        logic [287:0] t;
        t = {32'hA5A5_A5A5, 256'h0};
        for (int k = 0; k < 32; k++) begin
            t[k*8 +: 8] = ident ? (base | 8'(k)) : base;
            if (k == hole) t[k*8 +: 8] = hole_v;
        end
        return t;
    endfunction

    // Call #1 after an edge; the next edge is the start edge.
    task automatic start_run(input logic [7:0] ph, input logic [47:0] msg, input logic [287:0] tbl);
        previous_hash = ph;
        message       = msg;
        random_table  = tbl;
        enable_mining = 1'b1;
        @(posedge clock);
        #1;
        start_cyc = cyc;
    endtask

    task automatic wait_event(input int n0, input int limit);
        int k;
        k = 0;
        while (events_seen == n0 && k < limit) begin
            @(posedge clock);
            #2;
            k++;
        end
        if (events_seen == n0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no result within %0d cycles", limit);
        end
    endtask

    task automatic stop_run(input string tag);
        #1;
        enable_mining = 1'b0;
        @(posedge clock);
        #1;
        check({tag, "_state_idle"}, 64'(st[sel]), 64'd0);
        check({tag, "_done_low"}, 64'(done[sel]), 64'd0);
        check({tag, "_fail_low"}, 64'(failed[sel]), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int rel);
        while (cyc < start_cyc + rel) begin
            @(posedge clock);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [287:0] tbl_s2;
        int n0;
        tbl_s2 = tbl_fill(8'hFF, 1'b0, 5, 8'h05);

        reset = 1'b1;
        enable_mining = 1'b0;
        previous_hash = 8'h00;
        message = 48'h0;
        random_table = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_hash", 64'(hsh[0]), 64'd0);
        check("rst_nonce", 64'(nnc[0]), 64'd0);
        check("rst_final", fmsg[0], 64'd0);
        check("rst_done", 64'(done[0]), 64'd0);
        check("rst_failed", 64'(failed[0]), 64'd0);
        check("rst_state", 64'(st[0]), 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Scenario 1: identity table, all zero inputs.
        sel = 0;
        exp_q.push_back(mk_exp(1'b0, 9, 8'h00, 8'h00, 64'h0));
        n0 = events_seen;
        start_run(8'h00, 48'h0, tbl_fill(8'h00, 1'b1, -1, 8'h00));
        check("s1_busy", 64'(busy[0]), 64'd1);
        wait_event(n0, 40);
        repeat (3) @(posedge clock);
        #1;
        check("s1_done_held", 64'(done[0]), 64'd1);
        check("s1_busy_done", 64'(busy[0]), 64'd0);
        stop_run("s1");

        // Abort during HASH: enable drops in cycle 4.
        start_run(8'h00, 48'h0, tbl_s2);
        wait_until(3);
        enable_mining = 1'b0;
        @(posedge clock);
        #1;
        check("abort_state", 64'(st[0]), 64'd0);
        check("abort_busy", 64'(busy[0]), 64'd0);
        check("abort_done", 64'(done[0]), 64'd0);
        check("abort_nonce", 64'(nnc[0]), 64'd0);
        check("abort_final", fmsg[0], 64'd0);
        @(posedge clock);
        #1;

        // Scenario 2 restart; inputs scrambled after start must not matter.
        exp_q.push_back(mk_exp(1'b0, 217, 8'h1A, 8'h05, 64'h1A05_0000_0000_0000));
        n0 = events_seen;
        start_run(8'h00, 48'h0, tbl_s2);
        wait_until(2);
        previous_hash = 8'h55;
        message = 48'hFFFF_FFFF_FFFF;
        random_table = {288{1'b1}};
        wait_event(n0, 400);
        stop_run("s2");

        // Reset at cycle 100 of scenario 2, enable held through release.
        start_run(8'h00, 48'h0, tbl_s2);
        wait_until(99);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_busy", 64'(busy[0]), 64'd0);
        check("mid_rst_hash", 64'(hsh[0]), 64'd0);
        check("mid_rst_nonce", 64'(nnc[0]), 64'd0);
        check("mid_rst_final", fmsg[0], 64'd0);
        check("mid_rst_state", 64'(st[0]), 64'd0);
        exp_q.push_back(mk_exp(1'b0, 217, 8'h1A, 8'h05, 64'h1A05_0000_0000_0000));
        n0 = events_seen;
        reset = 1'b0;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        wait_event(n0, 400);
        stop_run("s4");

        // DIFFICULTY 0 accepts nonce 0 whatever the hash.
        sel = 2;
        exp_q.push_back(mk_exp(1'b0, 9, 8'h00, 8'hE0, 64'h00E0_0000_0000_0000));
        n0 = events_seen;
        start_run(8'h00, 48'h0, tbl_fill(8'hE0, 1'b1, -1, 8'h00));
        wait_event(n0, 40);
        stop_run("s5");

        // Every hash has its MSB set, so DIFFICULTY 1 never accepts.
        sel = 1;
`ifdef MINER_TIMEOUT_EN
        exp_q.push_back(mk_exp(1'b1, 2049, 8'h00, 8'h00, 64'h0));
        n0 = events_seen;
        start_run(8'h00, 48'h0, tbl_fill(8'hE0, 1'b1, -1, 8'h00));
        wait_event(n0, 2200);
        repeat (2) @(posedge clock);
        #1;
        check("s3_fail_held", 64'(failed[1]), 64'd1);
        check("s3_no_done", 64'(done[1]), 64'd0);
        stop_run("s3");
`else
        n0 = events_seen;
        start_run(8'h00, 48'h0, tbl_fill(8'hE0, 1'b1, -1, 8'h00));
        wait_until(4001);
        check("s3_busy_4001", 64'(busy[1]), 64'd1);
        check("s3_no_fail", 64'(failed[1]), 64'd0);
        check("s3_no_done", 64'(done[1]), 64'd0);
        check("s3_no_event", 64'(events_seen - n0), 64'd0);
        stop_run("s3");
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
